// File: rtl/mul_pkg.sv
// Shared encodings and sizing helpers for the pipelined integer multiplier.
package mul_pkg;

    // RV32M multiply operation encodings carried on in_op.
    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    // Stage-record field widths.
    localparam int OP_W        = 2;
    localparam int BOOTH_SEL_W = 4;

    // Number of radix-8 Booth digits for an (xlen+1)-bit signed multiplier,
    // i.e. NUM_PP = ceil((xlen+2)/3).
    function automatic int num_pp(input int xlen);
        return (xlen + 2 + 2) / 3;
    endfunction

    // A partial product spans -4A..+4A for an (xlen+1)-bit signed A.
    function automatic int pp_w(input int xlen);
        return xlen + 4;
    endfunction

    // rs1 is treated as signed for MULH and MULHSU.
    function automatic logic op_a_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    // rs2 is treated as signed for MULH only.
    function automatic logic op_b_signed(input logic [1:0] op);
        return op == MUL_OP_MULH;
    endfunction

    // Every op except MUL returns the upper half of the product.
    function automatic logic op_high(input logic [1:0] op);
        logic high;
        case (op)
            MUL_OP_MUL:                              high = 1'b0;
            MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: high = 1'b1;
            default:                                 high = 1'b1;
        endcase
        return high;
    endfunction

endpackage

// File: rtl/booth8_pp.sv
// Radix-8 Booth partial-product generator: selects 0, +-A, +-2A, +-3A, +-4A
// from a 4-bit window {b[3i+2], b[3i+1], b[3i], b[3i-1]} of the multiplier.
module booth8_pp
    import mul_pkg::*;
#(
    parameter int W = 36
) (
    input  logic [W-1:0]           a1,
    input  logic [W-1:0]           a3,
    input  logic [BOOTH_SEL_W-1:0] sel,
    output logic [W-1:0]           pp
);

    logic [W-1:0] mag;
    logic         neg;

    // Decode the Booth digit into a magnitude and a sign, then negate.
    always_comb begin
        neg = sel[3];
        unique case (sel)
            4'b0000, 4'b1111:                   mag = '0;
            4'b0001, 4'b0010, 4'b1101, 4'b1110: mag = a1;
            4'b0011, 4'b0100, 4'b1011, 4'b1100: mag = a1 << 1;
            4'b0101, 4'b0110, 4'b1001, 4'b1010: mag = a3;
            default:                            mag = a1 << 2;  // 0111 (+4), 1000 (-4)
        endcase
        pp = neg ? (~mag + 1'b1) : mag;
    end

endmodule

// File: rtl/csa.sv
// 3:2 carry-save adder; the carry vector is returned already weighted (<<1).
module csa #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] sum,
    output logic [W-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = {(a[W-2:0] & b[W-2:0]) | (a[W-2:0] & c[W-2:0]) | (b[W-2:0] & c[W-2:0]), 1'b0};

endmodule

// File: rtl/mul_pipe.sv
// Fully pipelined RV32M-style multiplier: Booth partial products in stage 0,
// carry-save reduction feeding optional delay stages, final add and half
// select in the last stage. One global stall freezes every stage.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 4,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int NUM_PP = num_pp(XLEN);
    localparam int PP_W   = pp_w(XLEN);
    localparam int PROD_W = 2 * XLEN;
    localparam int BB_W   = 3 * NUM_PP + 1;

    logic                         stall;
    logic [LATENCY-1:0]           vld_q, vld_d;
    logic [OP_W-1:0]              op_q  [LATENCY];
    logic [OP_W-1:0]              op_d  [LATENCY];
    logic [TAG_W-1:0]             tag_q [LATENCY];
    logic [TAG_W-1:0]             tag_d [LATENCY];
    logic [NUM_PP-1:0][PP_W-1:0]  pp_q, pp_d, pp_new;
    logic [XLEN-1:0]              res_q, res_d;

    logic [XLEN:0]                a_ext, b_ext;
    logic [PP_W-1:0]              a1, a3;
    logic [BB_W-1:0]              bb;
    logic [PROD_W-1:0]            term  [NUM_PP];
    logic [PROD_W-1:0]            red_s [1:NUM_PP-1];
    logic [PROD_W-1:0]            red_c [1:NUM_PP-1];
    logic [PROD_W-1:0]            fin_s, fin_c, prod;

    // Only the last stage can be blocked, and a blocked last stage freezes all.
    assign stall      = vld_q[LATENCY-1] && !out_ready;
    assign in_ready   = !stall;
    assign out_valid  = vld_q[LATENCY-1];
    assign out_result = res_q;
    assign out_tag    = tag_q[LATENCY-1];
    assign busy       = |vld_q;

    // Extend operands to XLEN+1 bits by op, and precompute A and 3A.
    always_comb begin
        a_ext = {op_a_signed(in_op) & in_a[XLEN-1], in_a};
        b_ext = {op_b_signed(in_op) & in_b[XLEN-1], in_b};
        a1    = {{(PP_W-XLEN-1){a_ext[XLEN]}}, a_ext};
        a3    = a1 + (a1 << 1);
        bb    = {{(BB_W-XLEN-2){b_ext[XLEN]}}, b_ext, 1'b0};
    end

    for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
        booth8_pp #(.W(PP_W)) u_pp (
            .a1  (a1),
            .a3  (a3),
            .sel (bb[3*i +: BOOTH_SEL_W]),
            .pp  (pp_new[i])
        );
    end

    // Weight each registered partial product by 8^i in the 2*XLEN product.
    always_comb begin
        for (int i = 0; i < NUM_PP; i++) begin
            term[i] = {{(PROD_W-PP_W){pp_q[i][PP_W-1]}}, pp_q[i]} << (3 * i);
        end
    end

    // Carry-save chain folds all partial products into one sum/carry pair.
    assign red_s[1] = term[0];
    assign red_c[1] = term[1];
    for (genvar i = 2; i < NUM_PP; i++) begin : g_red
        csa #(.W(PROD_W)) u_csa (
            .a     (red_s[i-1]),
            .b     (red_c[i-1]),
            .c     (term[i]),
            .sum   (red_s[i]),
            .carry (red_c[i])
        );
    end

    if (LATENCY == 2) begin : g_direct
        // With two stages the reduction and final add share the last stage.
        assign fin_s = red_s[NUM_PP-1];
        assign fin_c = red_c[NUM_PP-1];
    end else begin : g_mid
        localparam int N_MID = LATENCY - 2;
        logic [PROD_W-1:0] mid_s_q [N_MID];
        logic [PROD_W-1:0] mid_s_d [N_MID];
        logic [PROD_W-1:0] mid_c_q [N_MID];
        logic [PROD_W-1:0] mid_c_d [N_MID];

        // Register the reduced pair, then carry it through the delay stages.
        always_comb begin
            mid_s_d = mid_s_q;
            mid_c_d = mid_c_q;
            if (!stall) begin
                mid_s_d[0] = red_s[NUM_PP-1];
                mid_c_d[0] = red_c[NUM_PP-1];
                for (int k = 1; k < N_MID; k++) begin
                    mid_s_d[k] = mid_s_q[k-1];
                    mid_c_d[k] = mid_c_q[k-1];
                end
            end
        end

        // Middle-stage datapath registers; their stage valid bit qualifies them.
        always_ff @(posedge clk) begin
            mid_s_q <= mid_s_d;
            mid_c_q <= mid_c_d;
        end

        assign fin_s = mid_s_q[N_MID-1];
        assign fin_c = mid_c_q[N_MID-1];
    end

    assign prod = fin_s + fin_c;

    // Next-state for the stage records: hold on stall, else shift by one.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a latch.
        vld_d = vld_q;
        op_d  = op_q;
        tag_d = tag_q;
        pp_d  = pp_q;
        res_d = res_q;
        if (!stall) begin
            vld_d    = {vld_q[LATENCY-2:0], in_valid};
            op_d[0]  = in_op;
            tag_d[0] = in_tag;
            for (int k = 1; k < LATENCY; k++) begin
                op_d[k]  = op_q[k-1];
                tag_d[k] = tag_q[k-1];
            end
            pp_d  = pp_new;
            res_d = op_high(op_q[LATENCY-2]) ? prod[PROD_W-1:XLEN] : prod[XLEN-1:0];
        end
        // Flush kills everything in flight, including this cycle's accept,
        // and overrides a stall.
        if (flush) begin
            vld_d = '0;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so all stages update from old values.
        if (rst) begin
            vld_q <= '0;
            op_q  <= '{default: '0};
            tag_q <= '{default: '0};
            res_q <= '0;
        end else begin
            vld_q <= vld_d;
            op_q  <= op_d;
            tag_q <= tag_d;
            res_q <= res_d;
        end
    end

    // Partial-product registers.
    always_ff @(posedge clk) begin
        // NOTE: wide datapath registers skip reset; the valid bits guard them.
        pp_q <= pp_d;
    end

endmodule
